// File: rtl/mux_tree_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared constants, helper function and elaboration checks for
//               the pipelined multiplexer tree.
// Revision    : 1.0 - initial release
// ============================================================================

package mux_pkg;

  // Smallest legal tree: a single 2:1 level.
  localparam int MUX_MIN_INPUTS = 2;

  // Ceiling log2, usable in constant expressions. clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage : mux_pkg

`ifndef MUX_ASSERT_POW2
`define MUX_ASSERT_POW2(N) \
  if (((N) < mux_pkg::MUX_MIN_INPUTS) || (((N) & ((N) - 1)) != 0)) begin : g_bad_num_inputs \
    $error("NUM_INPUTS must be a power of two and at least 2"); \
  end
`endif

`default_nettype wire

// File: rtl/mux_tree_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_pipe_if
// Description : Valid/ready bundle carrying the flattened input channels and
//               select into the tree and the selected word out of it.
// Revision    : 1.0 - initial release
// ============================================================================

interface mux_tree_pipe_if
  import mux_pkg::*;
#(
  parameter int NUM_INPUTS = 256,
  parameter int DATA_WIDTH = 1
);

  localparam int SEL_WIDTH = clog2(NUM_INPUTS);

  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
  logic [SEL_WIDTH-1:0]             in_sel;
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            out_data;
  logic                             out_valid;
  logic                             out_ready;

  // Producer/consumer side (drives inputs, accepts results).
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Multiplexer tree side.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface : mux_tree_pipe_if

`default_nettype wire

// File: rtl/mux_tree_stage.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_stage
// Description : One registered level of the multiplexer tree. Halves the word
//               count with 2:1 selects steered by the select LSB and forwards
//               the remaining select bits alongside the partial words.
// Revision    : 1.0 - initial release
// ============================================================================

module mux_tree_stage
  import mux_pkg::*;
#(
  parameter int N_IN       = MUX_MIN_INPUTS,
  parameter int DATA_WIDTH = 1,
  parameter int SEL_IN     = 1,
  parameter int SEL_OUT    = (SEL_IN > 1) ? SEL_IN - 1 : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_stall,
  input  logic [N_IN*DATA_WIDTH-1:0]         i_data,
  input  logic [SEL_IN-1:0]                  i_sel,
  input  logic                               i_valid,
  output logic [(N_IN/2)*DATA_WIDTH-1:0]     o_data,
  output logic [SEL_OUT-1:0]                 o_sel,
  output logic                               o_valid
);

  localparam int c_n_out = N_IN / 2;

  logic [c_n_out*DATA_WIDTH-1:0] w_mux;
  logic [c_n_out*DATA_WIDTH-1:0] r_data;
  logic                          r_valid;
  logic                          w_advance;
  logic                          w_load;

  // Valid bits move every unstalled cycle; payload only moves with a valid
  // word so bubbles leave the previous contents untouched.
  assign w_advance = !i_stall;
  assign w_load    = w_advance && i_valid;

  // Pair (2j, 2j+1) collapses to word j; select LSB = 0 picks the even word.
  always_comb begin
    w_mux = '0;
    for (int j = 0; j < c_n_out; j++) begin
      w_mux[j*DATA_WIDTH +: DATA_WIDTH] = i_sel[0]
        ? i_data[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]
        : i_data[(2*j)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Partial-word register, held during stalls and bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (w_load) begin
      r_data <= w_mux;
    end
  end

  // Stage valid bit, frozen only by the global stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      r_valid <= i_valid;
    end
  end

  if (SEL_IN > 1) begin : g_sel_reg
    logic [SEL_OUT-1:0] r_sel;

    // Unconsumed select bits travel with their data.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sel <= '0;
      end else if (w_load) begin
        r_sel <= i_sel[SEL_IN-1:1];
      end
    end

    assign o_sel = r_sel;
  end else begin : g_sel_last
    // Final level consumes the last select bit; nothing left to forward.
    assign o_sel = '0;
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule : mux_tree_stage

`default_nettype wire

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_pipe
// Description : Pipelined N:1 multiplexer tree with valid/ready handshake and
//               global back-pressure. One registered level per select bit.
// Revision    : 1.0 - initial release
// ============================================================================

module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int NUM_INPUTS = 256,
  parameter int DATA_WIDTH = 1,
  parameter int SEL_WIDTH  = clog2(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             rst,
  mux_tree_pipe_if.slave   bus
);

  `MUX_ASSERT_POW2(NUM_INPUTS)

  if (SEL_WIDTH != clog2(NUM_INPUTS)) begin : g_bad_sel_width
    $error("SEL_WIDTH is derived from NUM_INPUTS and must not be overridden");
  end

  logic w_stall;

  // A result that cannot leave freezes the whole tree; bubbles never stall.
  assign w_stall      = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !w_stall;

  for (genvar i = 0; i < SEL_WIDTH; i++) begin : g_stage
    localparam int c_n_in    = NUM_INPUTS >> i;
    localparam int c_sel_in  = SEL_WIDTH - i;
    localparam int c_sel_out = (c_sel_in > 1) ? c_sel_in - 1 : 1;

    logic [c_n_in*DATA_WIDTH-1:0]       w_data_in;
    logic [c_sel_in-1:0]                w_sel_in;
    logic                               w_valid_in;
    logic [(c_n_in/2)*DATA_WIDTH-1:0]   w_data_out;
    logic [c_sel_out-1:0]               w_sel_out;
    logic                               w_valid_out;

    if (i == 0) begin : g_first
      assign w_data_in  = bus.in_data;
      assign w_sel_in   = bus.in_sel;
      assign w_valid_in = bus.in_valid;
    end else begin : g_next
      assign w_data_in  = g_stage[i-1].w_data_out;
      assign w_sel_in   = g_stage[i-1].w_sel_out;
      assign w_valid_in = g_stage[i-1].w_valid_out;
    end

    mux_tree_stage #(
      .N_IN       (c_n_in),
      .DATA_WIDTH (DATA_WIDTH),
      .SEL_IN     (c_sel_in),
      .SEL_OUT    (c_sel_out)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_stall (w_stall),
      .i_data  (w_data_in),
      .i_sel   (w_sel_in),
      .i_valid (w_valid_in),
      .o_data  (w_data_out),
      .o_sel   (w_sel_out),
      .o_valid (w_valid_out)
    );
  end

  assign bus.out_data  = g_stage[SEL_WIDTH-1].w_data_out;
  assign bus.out_valid = g_stage[SEL_WIDTH-1].w_valid_out;

endmodule : mux_tree_pipe

`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_tree_pipe
// Description : Self-checking bench: directed scenarios on an 8x8 tree and a
//               randomised stream on the default 256x1 tree, both scored
//               against in-order expectation queues.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_mux_tree_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;

  mux_tree_pipe_if #(.NUM_INPUTS(8),   .DATA_WIDTH(8)) bus_a ();
  mux_tree_pipe_if #(.NUM_INPUTS(256), .DATA_WIDTH(1)) bus_b ();

  mux_tree_pipe #(.NUM_INPUTS(8), .DATA_WIDTH(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  mux_tree_pipe #(.NUM_INPUTS(256), .DATA_WIDTH(1)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  // Scoreboards: push on accepted input, pop and compare on consumed output.
  logic [7:0] q_a[$];
  logic       q_b[$];
  int         popped_a = 0;
  int         popped_b = 0;
  logic [7:0] exp_a;
  logic       exp_b;

  // Inputs change 2 time units after a rising edge, so the falling edge sees
  // exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_a.in_valid && bus_a.in_ready) q_a.push_back(8'h10 + 8'(bus_a.in_sel));
      if (bus_a.out_valid && bus_a.out_ready) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL sb_a_extra: out_data=%h produced with no pending transfer", bus_a.out_data);
        end else begin
          exp_a = q_a.pop_front();
          popped_a++;
          if (bus_a.out_data !== exp_a) begin
            errors++;
            $display("FAIL sb_a_data: got %h expected %h", bus_a.out_data, exp_a);
          end
        end
      end
      if (bus_b.in_valid && bus_b.in_ready) q_b.push_back(bus_b.in_data[bus_b.in_sel]);
      if (bus_b.out_valid && bus_b.out_ready) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL sb_b_extra: out_data=%b produced with no pending transfer", bus_b.out_data);
        end else begin
          exp_b = q_b.pop_front();
          popped_b++;
          if (bus_b.out_data !== exp_b) begin
            errors++;
            $display("FAIL sb_b_data: got %b expected %b (transfer %0d)", bus_b.out_data, exp_b, popped_b);
          end
        end
      end
    end
  end

  task automatic next_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    next_slot();
    checks++;
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid: got %b expected 0", bus_a.out_valid); end
    checks++;
    if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready: got %b expected 1", bus_a.in_ready); end
    checks++;
    if (bus_a.out_data !== 8'h00) begin errors++; $display("FAIL reset_a_out_data: got %h expected 00", bus_a.out_data); end
    checks++;
    if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %b expected 0", bus_b.out_valid); end
    checks++;
    if (bus_b.in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready: got %b expected 1", bus_b.in_ready); end
    checks++;
    if (bus_b.out_data !== 1'b0) begin errors++; $display("FAIL reset_b_out_data: got %b expected 0", bus_b.out_data); end
    rst = 1'b0;
    bus_a.out_ready = 1'b1;
  endtask

  task automatic test_single();
    for (int c = 0; c < 6; c++) begin
      bus_a.in_valid = (c == 0);
      bus_a.in_sel   = 3'd5;
      @(negedge clk);
      checks++;
      if (bus_a.out_valid !== (c == 3)) begin
        errors++;
        $display("FAIL single_valid: cycle %0d got %b expected %b", c, bus_a.out_valid, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (bus_a.out_data !== 8'h15) begin errors++; $display("FAIL single_data: got %h expected 15", bus_a.out_data); end
      end
      next_slot();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] expd;
    for (int c = 0; c < 13; c++) begin
      bus_a.in_valid = (c < 8);
      bus_a.in_sel   = 3'(c);
      @(negedge clk);
      checks++;
      if (bus_a.out_valid !== (c >= 3 && c < 11)) begin
        errors++;
        $display("FAIL b2b_valid: cycle %0d got %b expected %b", c, bus_a.out_valid, (c >= 3 && c < 11));
      end
      if (c >= 3 && c < 11) begin
        expd = 8'h10 + 8'(c - 3);
        checks++;
        if (bus_a.out_data !== expd) begin errors++; $display("FAIL b2b_data: cycle %0d got %h expected %h", c, bus_a.out_data, expd); end
      end
      next_slot();
    end
  endtask

  task automatic test_stall();
    int idx;
    int base;
    logic acc;
    idx  = 0;
    base = popped_a;
    for (int c = 0; c < 20; c++) begin
      bus_a.out_ready = !(c >= 5 && c <= 8);
      bus_a.in_valid  = (idx < 8);
      bus_a.in_sel    = 3'(idx);
      @(negedge clk);
      if (c >= 5 && c <= 8) begin
        checks++;
        if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", c, bus_a.in_ready); end
        checks++;
        if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 8'h12) begin
          errors++;
          $display("FAIL stall_hold: cycle %0d got valid=%b data=%h expected valid=1 data=12", c, bus_a.out_valid, bus_a.out_data);
        end
      end
      acc = bus_a.in_valid && bus_a.in_ready;
      next_slot();
      if (acc) idx++;
    end
    bus_a.out_ready = 1'b1;
    checks++;
    if (idx != 8) begin errors++; $display("FAIL stall_accepted: got %0d expected 8", idx); end
    checks++;
    if (popped_a - base != 8 || q_a.size() != 0) begin
      errors++;
      $display("FAIL stall_count: popped %0d pending %0d expected popped 8 pending 0", popped_a - base, q_a.size());
    end
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 3; c++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_sel   = 3'(c + 1);
      next_slot();
    end
    bus_a.in_valid = 1'b0;
    checks++;
    if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b expected 1", bus_a.out_valid); end
    rst = 1'b1;
    #1;
    checks++;
    if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async_valid: got %b expected 0", bus_a.out_valid); end
    checks++;
    if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", bus_a.in_ready); end
    q_a.delete();
    q_b.delete();
    next_slot();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus_a.in_valid = (c == 0);
      bus_a.in_sel   = 3'd7;
      @(negedge clk);
      checks++;
      if (bus_a.out_valid !== (c == 3)) begin
        errors++;
        $display("FAIL rstmid_valid: cycle %0d got %b expected %b", c, bus_a.out_valid, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (bus_a.out_data !== 8'h17) begin errors++; $display("FAIL rstmid_data: got %h expected 17", bus_a.out_data); end
      end
      next_slot();
    end
  endtask

  task automatic test_bubbles();
    logic ev;
    for (int c = 0; c < 9; c++) begin
      bus_a.in_valid = (c < 4) && (c % 2 == 0);
      bus_a.in_sel   = (c == 0) ? 3'd2 : 3'd4;
      @(negedge clk);
      ev = (c >= 3) && (c < 7) && ((c - 3) % 2 == 0);
      checks++;
      if (bus_a.out_valid !== ev) begin
        errors++;
        $display("FAIL bubble_valid: cycle %0d got %b expected %b", c, bus_a.out_valid, ev);
      end
      next_slot();
    end
  endtask

  task automatic test_random();
    int acc_cnt;
    int cyc;
    acc_cnt = 0;
    cyc     = 0;
    while (acc_cnt < 10000 && cyc < 60000) begin
      for (int w = 0; w < 8; w++) bus_b.in_data[w*32 +: 32] = $urandom;
      bus_b.in_sel    = 8'($urandom_range(0, 255));
      bus_b.in_valid  = ($urandom_range(0, 9) < 8);
      bus_b.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      checks++;
      if (bus_b.in_ready !== !(bus_b.out_valid && !bus_b.out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready: cycle %0d got %b with out_valid=%b out_ready=%b", cyc, bus_b.in_ready, bus_b.out_valid, bus_b.out_ready);
      end
      if (bus_b.in_valid && bus_b.in_ready) acc_cnt++;
      next_slot();
      cyc++;
    end
    checks++;
    if (acc_cnt != 10000) begin errors++; $display("FAIL rand_timeout: accepted %0d expected 10000", acc_cnt); end
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) next_slot();
    checks++;
    if (popped_b != acc_cnt || q_b.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: popped %0d pending %0d expected popped %0d pending 0", popped_b, q_b.size(), acc_cnt);
    end
  endtask

  initial begin
    bus_a.in_data   = '0;
    bus_a.in_sel    = '0;
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    bus_b.in_data   = '0;
    bus_b.in_sel    = '0;
    bus_b.in_valid  = 1'b0;
    bus_b.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) bus_a.in_data[k*8 +: 8] = 8'h10 + 8'(k);

    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_bubbles();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux_tree_pipe

`default_nettype wire
